// File: rtl/jtkiwi_paldma.sv
// Palette upload engine: copies a block of ROM bytes into the palette RAM
// through the shared CPU-side write port. The CPU always has priority on the
// port, and writes can optionally be confined to vertical blank.
module jtkiwi_paldma #(
    parameter int AW      = 10,
    parameter int RW      = 22,
    parameter bit VB_ONLY = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [RW-1:0] src_base,
    input  logic [AW:0]   len,
    input  logic          LVBL,
    input  logic          cpu_pal_we,
    output logic          rom_cs,
    output logic [RW-1:0] rom_addr,
    input  logic          rom_ok,
    input  logic [7:0]    rom_data,
    output logic [AW-1:0] pal_addr,
    output logic [7:0]    pal_dout,
    output logic          pal_we,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_WR,
        ST_FIN
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] rom_addr_q, rom_addr_d;
    logic [AW-1:0] pal_addr_q, pal_addr_d;
    logic [7:0]    pal_dout_q, pal_dout_d;
    logic [AW:0]   remain_q, remain_d;
    logic          nolen_q, nolen_d;   // zero-length start: done pulse without busy
    logic          wr_ok;

    // The port is free when the CPU is not using it and, if restricted, during blank
    assign wr_ok = !cpu_pal_we && (!VB_ONLY || !LVBL);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rom_addr_q <= '0;
            pal_addr_q <= '0;
            pal_dout_q <= '0;
            remain_q   <= '0;
            nolen_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            pal_addr_q <= pal_addr_d;
            pal_dout_q <= pal_dout_d;
            remain_q   <= remain_d;
            nolen_q    <= nolen_d;
        end
    end

    // Next-state logic: fetch one byte, write it, repeat until the count runs out
    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        pal_addr_d = pal_addr_q;
        pal_dout_d = pal_dout_q;
        remain_d   = remain_q;
        nolen_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        rom_addr_d = src_base;
                        pal_addr_d = '0;
                        remain_d   = len;
                        state_d    = ST_REQ;
                    end else begin
                        nolen_d = 1'b1;
                    end
                end
            end
            // rom_ok here may belong to the previous address, so it is not looked at
            ST_REQ: state_d = ST_WAIT;
            ST_WAIT: begin
                if (rom_ok) begin
                    pal_dout_d = rom_data;
                    state_d    = ST_WR;
                end
            end
            ST_WR: begin
                if (wr_ok) begin
                    rom_addr_d = rom_addr_q + 1'b1;
                    remain_d   = remain_q - 1'b1;
                    if (remain_q == {{AW{1'b0}}, 1'b1}) begin
                        // Last byte: leave pal_addr on the final address written
                        state_d = ST_FIN;
                    end else begin
                        pal_addr_d = pal_addr_q + 1'b1;
                        state_d    = ST_REQ;
                    end
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign rom_cs   = (state_q == ST_REQ) || (state_q == ST_WAIT);
    assign rom_addr = rom_addr_q;
    assign pal_addr = pal_addr_q;
    assign pal_dout = pal_dout_q;
    assign pal_we   = (state_q == ST_WR) && wr_ok;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_FIN) || nolen_q;

endmodule

// File: tb/tb_jtkiwi_paldma.sv
// Randomised bench for jtkiwi_paldma with a transaction-level reference model:
// a queue of expected palette writes, plus cycle bookkeeping for busy/done.
module tb_jtkiwi_paldma;

    localparam int AW  = 10;
    localparam int RW  = 22;
    localparam int BIG = 32'h7fff_ffff;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [RW-1:0] src_base = '0;
    logic [AW:0]   len = '0;
    logic          LVBL = 1'b0;
    logic          cpu_pal_we = 1'b0;
    logic          rom_ok = 1'b0;
    logic [7:0]    rom_data = '0;
    logic          rom_cs;
    logic [RW-1:0] rom_addr;
    logic [AW-1:0] pal_addr;
    logic [7:0]    pal_dout;
    logic          pal_we;
    logic          busy;
    logic          done;

    jtkiwi_paldma #(.AW(AW), .RW(RW), .VB_ONLY(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .src_base   (src_base),
        .len        (len),
        .LVBL       (LVBL),
        .cpu_pal_we (cpu_pal_we),
        .rom_cs     (rom_cs),
        .rom_addr   (rom_addr),
        .rom_ok     (rom_ok),
        .rom_data   (rom_data),
        .pal_addr   (pal_addr),
        .pal_dout   (pal_dout),
        .pal_we     (pal_we),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [AW-1:0] pa;
        logic [RW-1:0] ra;
        logic [7:0]    d;
    } wr_t;
    wr_t exp_q[$];

    // Model state
    int busy_from  = BIG;
    int busy_until = -1;
    int done_at    = -1;
    int cs_due     = -1;
    bit pending    = 1'b0;
    bit prev_cs    = 1'b0;
    int wr_count   = 0;

    // Stimulus knobs
    int minlat    = 0;
    int maxlat    = 0;
    bit stale     = 1'b0;
    int cpu_pct   = 0;
    int lvbl_mode = 0;

    function automatic logic [7:0] rom_byte(input logic [RW-1:0] a);
        return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]} ^ 8'h5A;
    endfunction

    function automatic bit busy_exp(input int c);
        return (c >= busy_from) && (c <= busy_until);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h cycle=%0d", tag, got, want, cyc);
        end
    endtask

    task automatic flush_model();
        exp_q.delete();
        busy_from  = BIG;
        busy_until = -1;
        done_at    = -1;
        cs_due     = -1;
        pending    = 1'b0;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // ROM responder: optional stale ok on the request cycle, then latency
    initial begin
        int cnt;
        int lat;
        bit pcs;
        cnt = 0;
        lat = 0;
        pcs = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rom_cs) begin
                if (!pcs) begin
                    cnt = 0;
                    lat = $urandom_range(maxlat, minlat);
                end else begin
                    cnt++;
                end
                if (cnt == 0 && stale) begin
                    rom_ok   = 1'b1;
                    rom_data = ~rom_byte(rom_addr);
                end else if (cnt >= 1 + lat) begin
                    rom_ok   = 1'b1;
                    rom_data = rom_byte(rom_addr);
                end else begin
                    rom_ok   = 1'b0;
                    rom_data = 8'($urandom);
                end
            end else begin
                rom_ok   = stale ? 1'($urandom_range(1, 0)) : 1'b0;
                rom_data = 8'($urandom);
            end
            pcs = rom_cs;
        end
    end

    // CPU port contention and vertical blank
    initial forever begin
        @(posedge clk);
        #1;
        cpu_pal_we = ($urandom_range(99, 0) < cpu_pct);
        if (lvbl_mode == 0)
            LVBL = 1'b0;
        else if ($urandom_range(15, 0) == 0)
            LVBL = ~LVBL;
    end

    // Monitor: compare every cycle against the model
    initial forever begin
        bit  be;
        wr_t e;
        @(negedge clk);
        if (!rst_n) begin
            prev_cs = 1'b0;
        end else begin
            be = busy_exp(cyc);
            chk("busy", 32'(busy), 32'(be));
            chk("done", 32'(done), 32'(cyc == done_at));
            if (!be) chk("cs_idle", 32'(rom_cs), 32'd0);
            if (cyc == cs_due) chk("cs_req", 32'(rom_cs), 32'd1);
            if (rom_cs && exp_q.size() > 0) chk("rom_addr", 32'(rom_addr), 32'(exp_q[0].ra));
            if (prev_cs && !rom_cs && be) pending = 1'b1;
            chk("pal_we", 32'(pal_we), 32'(pending && !cpu_pal_we && !LVBL));
            if (pal_we) begin
                if (exp_q.size() == 0) begin
                    chk("extra_wr", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pal_addr", 32'(pal_addr), 32'(e.pa));
                    chk("pal_dout", 32'(pal_dout), 32'(e.d));
                    wr_count++;
                    pending = 1'b0;
                    if (exp_q.size() == 0) begin
                        busy_until = cyc + 1;
                        done_at    = cyc + 1;
                    end else begin
                        cs_due = cyc + 1;
                    end
                end
            end
            prev_cs = rom_cs;
        end
    end

    task automatic do_start(input logic [RW-1:0] s, input int n);
        bit acc;
        @(posedge clk);
        #1;
        start    = 1'b1;
        src_base = s;
        len      = (AW+1)'(n);
        acc      = !busy_exp(cyc);
        if (acc) begin
            if (n == 0) begin
                done_at = cyc + 1;
            end else begin
                for (int i = 0; i < n; i++) begin
                    wr_t w;
                    w.pa = AW'(i);
                    w.ra = RW'(s + RW'(i));
                    w.d  = rom_byte(w.ra);
                    exp_q.push_back(w);
                end
                busy_from  = cyc + 1;
                busy_until = BIG;
                cs_due     = cyc + 1;
            end
        end
        $display("xfer src=%06h len=%0d accepted=%0d cycle=%0d", s, n, acc, cyc);
        @(posedge clk);
        #1;
        start    = 1'b0;
        src_base = RW'($urandom);
        len      = (AW+1)'($urandom);
    endtask

    task automatic wait_idle(input int budget);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || busy_exp(cyc) || cyc <= done_at) && t < budget) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("idle_in_time", 32'(t < budget), 32'd1);
        if (t >= budget) flush_model();
    endtask

    task automatic check_reset_outputs();
        chk("rst_rom_cs", 32'(rom_cs), 32'd0);
        chk("rst_pal_we", 32'(pal_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_pal_addr", 32'(pal_addr), 32'd0);
        chk("rst_pal_dout", 32'(pal_dout), 32'd0);
    endtask

    initial begin
        int base;
        #1;
        check_reset_outputs();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Basic copy, zero-wait ROM, free port
        do_start(22'h001000, 4);
        wait_idle(200);

        // Zero length
        do_start(22'h000123, 0);
        wait_idle(50);

        // Vertical blank gating
        lvbl_mode = 1;
        maxlat = 2;
        do_start(22'h002000, 16);
        wait_idle(2000);
        lvbl_mode = 0;

        // CPU contention
        cpu_pct = 60;
        do_start(22'h003000, 16);
        wait_idle(2000);
        cpu_pct = 0;

        // Stale ok on request, three low cycles, start while busy
        stale  = 1'b1;
        minlat = 3;
        maxlat = 3;
        do_start(22'h004000, 6);
        do_start(22'h00AAAA, 5);
        wait_idle(500);
        stale  = 1'b0;
        minlat = 0;
        maxlat = 0;

        // Reset in the middle of an 8-byte transfer
        base = wr_count;
        do_start(22'h005000, 8);
        for (int t = 0; t < 200 && wr_count < base + 2; t++) begin
            @(posedge clk);
            #1;
        end
        chk("two_bytes_before_reset", 32'(wr_count - base), 32'd2);
        #2;
        rst_n = 1'b0;
        flush_model();
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_start(22'h006000, 3);
        wait_idle(200);

        // ROM address wrap
        do_start(22'h3FFFFD, 6);
        wait_idle(200);

        // Full palette
        cpu_pal_we = 1'b0;
        cpu_pct = 10;
        maxlat  = 1;
        do_start(RW'($urandom), 1024);
        wait_idle(20000);

        // Random transfers
        for (int k = 0; k < 12; k++) begin
            cpu_pct   = $urandom_range(40, 0);
            lvbl_mode = $urandom_range(1, 0);
            stale     = 1'($urandom_range(1, 0));
            minlat    = 0;
            maxlat    = $urandom_range(3, 0);
            do_start(RW'($urandom), $urandom_range(40, 0));
            wait_idle(3000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
